ahb_lite_byte_master: RTL and testbench

- Byte-stream command bridge and AHB-Lite single-transfer master.
- Sits directly upstream of ahb_lite_sdram in place of the self-test master. A UART or JTAG byte front end feeds it.
- Decodes write/read command packets and issues one 32-bit NONSEQ transfer per command. Returns an ack byte or the read data bytes.
- Has no UART PHY inside; byte interfaces use valid/ready handshakes.

---
 rtl/ahb_lite_byte_master.sv | 206 ++++++++++++++++++++
 tb/tb_ahb_lite_byte_master.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_byte_master.sv
// Byte-stream command bridge: decodes 'W'/'R' packets from a valid/ready byte
// source and issues one 32-bit AHB-Lite SINGLE transfer per packet.
module ahb_lite_byte_master #(
    parameter int unsigned TIMEOUT_BITS = 21,
    parameter int unsigned RX_TIMEOUT   = 1000000,
    parameter logic [7:0]  ACK_BYTE     = 8'h4B,
    parameter logic [7:0]  ERR_BYTE     = 8'h45,
    parameter logic [7:0]  NAK_BYTE     = 8'h3F
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HSEL,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        BUSY
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_AHB_A, S_AHB_D, S_TX
    } state_t;

    localparam logic [TIMEOUT_BITS-1:0] TMO_LIMIT = TIMEOUT_BITS'(RX_TIMEOUT);
    localparam logic [TIMEOUT_BITS-1:0] TMO_ONE   = TIMEOUT_BITS'(1);
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    state_t                  state_q;
    logic [31:0]             addr_q, wdata_q, rdata_q, haddr_q;
    logic [1:0]              htrans_q, cnt_q, tx_left_q;
    logic                    hsel_q, hwrite_q, write_q, err_q;
    logic                    tx_valid_q, rx_ready_q, busy_q;
    logic [7:0]              tx_data_q;
    logic [TIMEOUT_BITS-1:0] tmo_q;

    logic        rx_fire, tx_fire, resp_err;
    logic [31:0] addr_shift, wdata_shift;

    assign rx_fire     = RX_VALID && rx_ready_q;
    assign tx_fire     = tx_valid_q && TX_READY;
    assign resp_err    = err_q | HRESP;
    assign addr_shift  = {addr_q[23:0], RX_DATA};
    assign wdata_shift = {wdata_q[23:0], RX_DATA};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            haddr_q    <= '0;
            htrans_q   <= TR_IDLE;
            hsel_q     <= 1'b0;
            hwrite_q   <= 1'b0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            tx_left_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rx_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    if (rx_fire) begin
                        busy_q <= 1'b1;
                        if (RX_DATA == CMD_W || RX_DATA == CMD_R) begin
                            write_q <= (RX_DATA == CMD_W);
                            cnt_q   <= '0;
                            tmo_q   <= '0;
                            state_q <= S_ADDR;
                        end else begin
                            tx_data_q  <= NAK_BYTE;
                            tx_valid_q <= 1'b1;
                            tx_left_q  <= '0;
                            rx_ready_q <= 1'b0;
                            state_q    <= S_TX;
                        end
                    end
                end

                S_ADDR: begin
                    if (rx_fire) begin
                        addr_q <= addr_shift;
                        cnt_q  <= cnt_q + 2'd1;
                        tmo_q  <= '0;
                        if (cnt_q == 2'd3) begin
                            cnt_q <= '0;
                            if (write_q) begin
                                state_q <= S_WDATA;
                            end else begin
                                rx_ready_q <= 1'b0;
                                haddr_q    <= {addr_shift[31:2], 2'b00};
                                htrans_q   <= TR_NONSEQ;
                                hsel_q     <= 1'b1;
                                hwrite_q   <= 1'b0;
                                state_q    <= S_AHB_A;
                            end
                        end
                    end else if (tmo_q == TMO_LIMIT) begin
                        tmo_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_ONE;
                    end
                end

                S_WDATA: begin
                    if (rx_fire) begin
                        wdata_q <= wdata_shift;
                        cnt_q   <= cnt_q + 2'd1;
                        tmo_q   <= '0;
                        if (cnt_q == 2'd3) begin
                            rx_ready_q <= 1'b0;
                            haddr_q    <= {addr_q[31:2], 2'b00};
                            htrans_q   <= TR_NONSEQ;
                            hsel_q     <= 1'b1;
                            hwrite_q   <= 1'b1;
                            state_q    <= S_AHB_A;
                        end
                    end else if (tmo_q == TMO_LIMIT) begin
                        tmo_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_ONE;
                    end
                end

                S_AHB_A: begin
                    if (HREADY) begin
                        htrans_q <= TR_IDLE;
                        hsel_q   <= 1'b0;
                        hwrite_q <= 1'b0;
                        state_q  <= S_AHB_D;
                    end
                end

                // Data phase: errors seen on any wait cycle stick until the response.
                S_AHB_D: begin
                    err_q <= resp_err;
                    if (HREADY) begin
                        if (!write_q) rdata_q <= HRDATA;
                        if (resp_err)     tx_data_q <= ERR_BYTE;
                        else if (write_q) tx_data_q <= ACK_BYTE;
                        else              tx_data_q <= HRDATA[31:24];
                        tx_left_q  <= (resp_err || write_q) ? 2'd0 : 2'd3;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_TX;
                    end
                end

                S_TX: begin
                    if (tx_fire) begin
                        if (tx_left_q != 2'd0) begin
                            tx_data_q <= rdata_q[23:16];
                            rdata_q   <= {rdata_q[23:0], 8'h00};
                            tx_left_q <= tx_left_q - 2'd1;
                        end else begin
                            tx_valid_q <= 1'b0;
                            err_q      <= 1'b0;
                            busy_q     <= 1'b0;
                            rx_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign HADDR    = haddr_q;
    assign HBURST   = 3'b000;
    assign HSEL     = hsel_q;
    assign HSIZE    = 3'b010;
    assign HTRANS   = htrans_q;
    assign HWDATA   = wdata_q;
    assign HWRITE   = hwrite_q;
    assign RX_READY = rx_ready_q;
    assign TX_DATA  = tx_data_q;
    assign TX_VALID = tx_valid_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_ahb_lite_byte_master.sv
// Directed bench for ahb_lite_byte_master: byte source/sink tasks and a
// word-addressed AHB slave model with programmable wait states and errors.
module tb_ahb_lite_byte_master;
    logic        HCLK, HRESETn;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HBURST, HSIZE;
    logic [1:0]  HTRANS;
    logic        HSEL, HWRITE, HREADY, HRESP;
    logic [7:0]  RX_DATA, TX_DATA;
    logic        RX_VALID, RX_READY, TX_VALID, TX_READY, BUSY;

    ahb_lite_byte_master #(.RX_TIMEOUT(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HADDR(HADDR), .HBURST(HBURST), .HSEL(HSEL), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .BUSY(BUSY)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_cmp = 0, n_fail = 0;
    int n_xfer = 0, stall_bad = 0, hold_bad = 0;
    int addr_wait = 0, data_wait = 0;
    bit err_mode = 0;
    logic [31:0] last_addr = '0, last_wdata = '0;
    logic [31:0] mem [256];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_haddr;
        int          nbytes;
        logic [31:0] exp_bytes;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Slave: stalls the address phase addr_wait cycles, the data phase data_wait cycles.
    initial begin
        logic [31:0] a;
        logic        w;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[4] = 32'hCAFEF00D;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        forever begin
            @(negedge HCLK);
            HREADY = 1'b1; HRESP = 1'b0;
            if (HSEL && HTRANS == 2'b10) begin
                a = HADDR; w = HWRITE;
                for (int i = 0; i < addr_wait; i++) begin
                    HREADY = 1'b0;
                    @(negedge HCLK);
                    if (HADDR !== a || HTRANS !== 2'b10 || HSEL !== 1'b1) stall_bad++;
                end
                HREADY = 1'b1;
                @(negedge HCLK);
                n_xfer++; last_addr = a;
                if (err_mode) begin
                    HREADY = 1'b0; HRESP = 1'b1;
                    @(negedge HCLK);
                    HREADY = 1'b1; HRESP = 1'b1;
                end else begin
                    for (int i = 0; i < data_wait; i++) begin
                        HREADY = 1'b0;
                        @(negedge HCLK);
                    end
                    HREADY = 1'b1;
                end
                if (w) begin
                    last_wdata = HWDATA;
                    if (!err_mode) mem[a[9:2]] = HWDATA;
                end else begin
                    HRDATA = mem[a[9:2]];
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge HCLK);
        RX_DATA = b; RX_VALID = 1'b1;
        while (!RX_READY && t < 100) begin
            @(negedge HCLK);
            t++;
        end
        if (!RX_READY) bound_fail("rx_ready_wait");
        @(negedge HCLK);
        RX_VALID = 1'b0;
    endtask

    task automatic send_pkt(input logic wr, input logic [31:0] a, input logic [31:0] d);
        send_byte(wr ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        if (wr) for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
    endtask

    task automatic recv_byte(input int hold, output logic [7:0] b, output bit ok);
        int t = 0;
        logic [7:0] first;
        ok = 1'b1; b = '0;
        while (!TX_VALID && t < 200) begin
            @(negedge HCLK);
            t++;
        end
        if (!TX_VALID) begin
            ok = 1'b0;
            return;
        end
        first = TX_DATA;
        for (int i = 0; i < hold; i++) begin
            @(negedge HCLK);
            if (TX_DATA !== first || TX_VALID !== 1'b1) hold_bad++;
        end
        b = TX_DATA;
        TX_READY = 1'b1;
        @(negedge HCLK);
        TX_READY = 1'b0;
    endtask

    task automatic expect_bytes(input int n, input logic [31:0] exp, input int hold);
        logic [7:0] b;
        bit ok;
        for (int i = 0; i < n; i++) begin
            recv_byte(hold, b, ok);
            if (!ok) begin
                bound_fail("tx_byte_wait");
                break;
            end
            check($sformatf("tx_byte%0d", i), 32'(b), 32'(exp[31-8*i -: 8]));
        end
        check("busy_after", 32'(BUSY), 32'h0);
        check("txvalid_after", 32'(TX_VALID), 32'h0);
    endtask

    task automatic run_vec(input vec_t v, input int hold);
        int x0;
        x0 = n_xfer;
        send_pkt(v.wr, v.addr, v.wdata);
        check("htrans_nonseq", 32'(HTRANS), 32'h2);
        check("hsel_addr", 32'(HSEL), 32'h1);
        check("haddr", HADDR, v.exp_haddr);
        check("hwrite", 32'(HWRITE), 32'(v.wr));
        expect_bytes(v.nbytes, v.exp_bytes, hold);
        check("xfer_count", 32'(n_xfer - x0), 32'h1);
        check("xfer_addr", last_addr, v.exp_haddr);
        if (v.wr) check("xfer_wdata", last_wdata, v.wdata);
    endtask

    initial begin
        int x0;
        vecs[0] = '{1'b1, 32'h0000_0100, 32'hDEADBEEF, 32'h0000_0100, 1, 32'h4B00_0000};
        vecs[1] = '{1'b0, 32'h0000_0100, 32'h0,        32'h0000_0100, 4, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 32'h0000_0103, 32'h0,        32'h0000_0100, 4, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 32'h0000_0042, 32'h12345678, 32'h0000_0040, 1, 32'h4B00_0000};
        vecs[4] = '{1'b0, 32'h0000_0040, 32'h0,        32'h0000_0040, 4, 32'h12345678};

        HRESETn = 1'b0; RX_VALID = 1'b0; RX_DATA = '0; TX_READY = 1'b0;
        #12;
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_hsel", 32'(HSEL), 32'h0);
        check("rst_hwrite", 32'(HWRITE), 32'h0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_txvalid", 32'(TX_VALID), 32'h0);
        check("rst_txdata", 32'(TX_DATA), 32'h0);
        check("rst_rxready", 32'(RX_READY), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
        check("hburst", 32'(HBURST), 32'h0);
        check("hsize", 32'(HSIZE), 32'h2);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
        check("idle_rxready", 32'(RX_READY), 32'h1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], 0);

        // Unknown command byte: NAK only, no bus activity.
        x0 = n_xfer;
        send_byte(8'h41);
        check("nak_htrans", 32'(HTRANS), 32'h0);
        expect_bytes(1, 32'h3F00_0000, 0);
        check("nak_no_xfer", 32'(n_xfer - x0), 32'h0);

        // Bus error on a read: single ERR byte.
        err_mode = 1'b1;
        x0 = n_xfer;
        send_pkt(1'b0, 32'h0000_0200, 32'h0);
        check("err_haddr", HADDR, 32'h0000_0200);
        expect_bytes(1, 32'h4500_0000, 0);
        check("err_xfer", 32'(n_xfer - x0), 32'h1);
        err_mode = 1'b0;

        // Inter-byte timeout drops a partial packet silently.
        x0 = n_xfer;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
        repeat (20) @(negedge HCLK);
        check("tmo_busy", 32'(BUSY), 32'h0);
        check("tmo_txvalid", 32'(TX_VALID), 32'h0);
        check("tmo_no_xfer", 32'(n_xfer - x0), 32'h0);
        run_vec('{1'b0, 32'h0000_0010, 32'h0, 32'h0000_0010, 4, 32'hCAFEF00D}, 0);

        // Address/data stalls and TX back-pressure.
        addr_wait = 7; data_wait = 5;
        run_vec(vecs[1], 10);
        check("addr_stall_stable", 32'(stall_bad), 32'h0);
        check("tx_hold_stable", 32'(hold_bad), 32'h0);
        addr_wait = 0;

        // Asynchronous reset while in the data phase.
        send_pkt(1'b0, 32'h0000_0040, 32'h0);
        @(negedge HCLK);
        check("pre_rst_busy", 32'(BUSY), 32'h1);
        check("pre_rst_htrans", 32'(HTRANS), 32'h0);
        #2 HRESETn = 1'b0;
        #1;
        check("arst_htrans", 32'(HTRANS), 32'h0);
        check("arst_txvalid", 32'(TX_VALID), 32'h0);
        check("arst_busy", 32'(BUSY), 32'h0);
        check("arst_haddr", HADDR, 32'h0);
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        data_wait = 0;
        repeat (10) @(negedge HCLK);
        check("post_rst_txvalid", 32'(TX_VALID), 32'h0);
        run_vec(vecs[4], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d mismatched so far", n_fail);
        $fatal(1);
    end

endmodule
